dcache_mem_port: RTL and testbench
==================================

Name: dcache_mem_port

Overview:
- Responder end of the load/store-buffer data-access interface.
- Accepts one byte, half-word or word read/write request at a time and serializes it onto the byte-wide external RAM/IO bus.
- Returns assembled read data with a one-cycle dataValid pulse, or signals write completion with a one-cycle dataWriteSuc pulse.
- Writes to the IO region are held off while the IO buffer reports full.

Parameters:
ADDR_WIDTH, 32, width of request and RAM addresses
IO_SEL_LSB, 16, low bit of the 2-bit IO-region selector; IO when addr[IO_SEL_LSB+1:IO_SEL_LSB]==2'b11

Ports:
clockIn  input  1  sole clock, rising edge
resetIn  input  1  asynchronous, active-low reset
accessType  input  2  request: 00 none, 01 byte, 10 half, 11 word; a request is the single cycle it is non-zero while idle
readWriteIn  input  1  1 read, 0 write
dataAddr  input  ADDR_WIDTH  request byte address
dataIn  input  32  write data, low bytes used
dataValid  output  1  one-cycle pulse: read data on dataOut
dataOut  output  32  assembled read data, zero-extended
dataWriteSuc  output  1  one-cycle pulse: write finished
busy  output  1  request in progress
memIn  input  8  RAM read byte, valid one cycle after memAddr is registered
memOut  output  8  RAM write byte
memAddr  output  ADDR_WIDTH  RAM byte address
memWr  output  1  1 write, 0 read
ioBufferFull  input  1  IO sink cannot take a byte

Behaviour:
- Reset (resetIn low, asynchronous): state IDLE; all outputs 0 (dataValid, dataWriteSuc, busy, memWr, memOut, memAddr, dataOut).
- N = 1, 2, 4 for accessType 01, 10, 11. Byte i lives at addr+i in bits [8i+7:8i] (little-endian). Addresses add with ADDR_WIDTH wrap-around.
- IDLE:
  - On edge k with accessType!=0, latch addr, data, N and direction; set busy.
  - Go to RD or WR.
  - accessType==0: stay in IDLE, memWr=0.
- RD:
  - Register memAddr=addr+i at edges k..k+N-1, with memWr=0.
  - Byte i is captured from memIn at edge k+i+2.
  - At edge k+N+1: dataValid=1 and dataOut = captured bytes, upper unused bytes 0. Return to IDLE and clear busy.
  - Word read: dataValid visible 5 cycles after the request edge.
- WR (non-IO):
  - At edges k..k+N-1: memAddr=addr+i, memOut=data byte i, memWr=1.
  - At edge k+N: memWr=0, dataWriteSuc=1, IDLE, busy clear.
- WR (IO region):
  - Before each byte, if ioBufferFull is sampled high, hold memWr=0 and keep the byte index.
  - Retry each cycle. Completion is delayed by the stalled cycles.
- Reads of the IO region are never stalled.
- Pulses:
  - dataValid and dataWriteSuc last exactly one cycle and are never high together.
  - busy deasserts at the same edge a pulse rises.
  - A new request is accepted no earlier than the next edge.
- Requests that arrive while busy are ignored entirely: no state change, no queuing.
- dataOut holds its last value until the next read completes.
- Reset mid-transaction aborts immediately. No pulse is issued and partial RAM writes are not rolled back.

Decomposition:
- Shared package:
  - access-type encodings (NONE, BYTE, HALF, WORD)
  - FSM state encoding (IDLE, RD, WR)
  - IO-region selector value 2'b11
- Function bytes_of(accessType) goes in the package.
- Single FSM module; no sub-module is warranted.

Test Plan:
- Word read at 0x100, RAM[0x100..0x103]=11,22,33,44 -> memAddr 100,101,102,103 on consecutive cycles; dataOut=0x44332211; dataValid single pulse at request edge +5.
- Half read at 0x0FFE, RAM=80,FF -> dataOut=0x0000FF80; byte read at 0x7 (RAM=0xA5) -> dataOut=0x000000A5, pulse at edge +2.
- Byte write 0xDEADBEAB to 0x203 -> one memWr cycle, addr 0x203, memOut=0xAB; dataWriteSuc at edge +1; neighbouring RAM unchanged.
- Half write 0x1234 to IO addr 0x30004, ioBufferFull high 3 cycles before byte 0 -> memWr held low 3 cycles; then bytes 0x34, 0x12 written; dataWriteSuc at edge +5.
- Second request issued 2 cycles into a word read -> ignored; only one dataValid; busy was high throughout.
- resetIn low mid word write after byte 1 -> all outputs 0 immediately; no dataWriteSuc; next request after release completes normally.

Source files
------------

// File: rtl/dcache_mem_port_pkg.sv
// Shared encodings for the data-cache memory port: request sizes, FSM states
// and the IO-region selector value.
package dcache_mem_port_pkg;

   typedef enum logic [1:0] {
      ACC_NONE = 2'b00,
      ACC_BYTE = 2'b01,
      ACC_HALF = 2'b10,
      ACC_WORD = 2'b11
   } accessTypeT;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RD   = 2'b01,
      ST_WR   = 2'b10
   } stateT;

   // Address selector value that marks the IO region.
   localparam logic [1:0] IO_SEL = 2'b11;

   // Number of bus bytes moved for a request size (0 for no request).
   function automatic logic [2:0] bytes_of(input logic [1:0] accessType);
      case (accessType)
         ACC_BYTE: bytes_of = 3'd1;
         ACC_HALF: bytes_of = 3'd2;
         ACC_WORD: bytes_of = 3'd4;
         default:  bytes_of = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/dcache_mem_port.sv
// Data-cache memory port: takes one byte/half/word request at a time from the
// load/store buffer and serializes it onto the byte-wide RAM/IO bus.
module dcache_mem_port
   import dcache_mem_port_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int IO_SEL_LSB = 16
) (
   input  logic                  clockIn,
   input  logic                  resetIn,
   input  logic [1:0]            accessType,
   input  logic                  readWriteIn,
   input  logic [ADDR_WIDTH-1:0] dataAddr,
   input  logic [31:0]           dataIn,
   output logic                  dataValid,
   output logic [31:0]           dataOut,
   output logic                  dataWriteSuc,
   output logic                  busy,
   input  logic [7:0]            memIn,
   output logic [7:0]            memOut,
   output logic [ADDR_WIDTH-1:0] memAddr,
   output logic                  memWr,
   input  logic                  ioBufferFull
);

   stateT                 state;
   logic [ADDR_WIDTH-1:0] addrLatch;
   logic [31:0]           dataLatch;
   logic [31:0]           rdAssembly;
   logic [2:0]            byteCount;
   logic [2:0]            step;
   logic                  isIo;

   logic                  reqIo;
   logic [2:0]            capIdx;
   logic [31:0]           capWord;
   logic [31:0]           wrShift;

   // Request address falls in the IO region.
   assign reqIo   = (dataAddr[IO_SEL_LSB+1:IO_SEL_LSB] == IO_SEL);
   // In RD, memIn carries the byte addressed two edges earlier.
   assign capIdx  = step - 3'd2;
   assign capWord = 32'(memIn) << {capIdx, 3'b000};
   // In WR, the byte to send next sits at the bottom of this shift.
   assign wrShift = dataLatch >> {step, 3'b000};

   // Single request FSM with all bus and handshake outputs registered.
   always_ff @(posedge clockIn or negedge resetIn) begin
      if (!resetIn) begin
         state        <= ST_IDLE;
         busy         <= 1'b0;
         dataValid    <= 1'b0;
         dataWriteSuc <= 1'b0;
         dataOut      <= '0;
         memWr        <= 1'b0;
         memOut       <= '0;
         memAddr      <= '0;
         addrLatch    <= '0;
         dataLatch    <= '0;
         rdAssembly   <= '0;
         byteCount    <= '0;
         step         <= '0;
         isIo         <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout so every branch sees pre-edge state.
         dataValid    <= 1'b0;
         dataWriteSuc <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               memWr <= 1'b0;
               if (accessType != ACC_NONE) begin
                  addrLatch  <= dataAddr;
                  dataLatch  <= dataIn;
                  byteCount  <= bytes_of(accessType);
                  isIo       <= reqIo;
                  rdAssembly <= '0;
                  busy       <= 1'b1;
                  if (readWriteIn) begin
                     // Byte 0 address goes out on the accept edge itself.
                     state   <= ST_RD;
                     memAddr <= dataAddr;
                     step    <= 3'd1;
                  end else if (reqIo && ioBufferFull) begin
                     state <= ST_WR;
                     step  <= 3'd0;
                  end else begin
                     state   <= ST_WR;
                     memAddr <= dataAddr;
                     memOut  <= dataIn[7:0];
                     memWr   <= 1'b1;
                     step    <= 3'd1;
                  end
               end
            end

            ST_RD: begin
               if (step < byteCount) begin
                  memAddr <= addrLatch + ADDR_WIDTH'(step);
               end
               if (step == byteCount + 3'd1) begin
                  dataOut   <= rdAssembly | capWord;
                  dataValid <= 1'b1;
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end else if (step >= 3'd2) begin
                  rdAssembly <= rdAssembly | capWord;
               end
               step <= step + 3'd1;
            end

            ST_WR: begin
               if (step == byteCount) begin
                  memWr        <= 1'b0;
                  dataWriteSuc <= 1'b1;
                  busy         <= 1'b0;
                  state        <= ST_IDLE;
               end else if (isIo && ioBufferFull) begin
                  // IO sink full: hold the byte index and retry next cycle.
                  memWr <= 1'b0;
               end else begin
                  memAddr <= addrLatch + ADDR_WIDTH'(step);
                  memOut  <= wrShift[7:0];
                  memWr   <= 1'b1;
                  step    <= step + 3'd1;
               end
            end

            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               memWr <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_mem_port.sv
// Directed bench for dcache_mem_port with a synchronous byte-RAM model.
module tb_dcache_mem_port;
   import dcache_mem_port_pkg::*;

   localparam int AW = 32;

   logic          clockIn = 1'b0;
   logic          resetIn;
   logic [1:0]    accessType;
   logic          readWriteIn;
   logic [AW-1:0] dataAddr;
   logic [31:0]   dataIn;
   logic          dataValid;
   logic [31:0]   dataOut;
   logic          dataWriteSuc;
   logic          busy;
   logic [7:0]    memIn;
   logic [7:0]    memOut;
   logic [AW-1:0] memAddr;
   logic          memWr;
   logic          ioBufferFull;

   // RAM model, preloaded through a poke port so only one process writes it.
   logic [7:0]  ram [0:4095];
   logic        preEn = 1'b0;
   logic [11:0] preAddr;
   logic [7:0]  preData;

   int errors = 0;
   int checks = 0;

   logic [AW-1:0] addrSeq [0:15];
   logic [7:0]    outSeq  [0:15];
   logic          wrSeq   [0:15];
   logic          busySeq [0:15];
   int validAt, sucAt, validCount, sucCount, wrCount, bothCount;

   dcache_mem_port #(.ADDR_WIDTH(AW), .IO_SEL_LSB(16)) dut (
      .clockIn      (clockIn),
      .resetIn      (resetIn),
      .accessType   (accessType),
      .readWriteIn  (readWriteIn),
      .dataAddr     (dataAddr),
      .dataIn       (dataIn),
      .dataValid    (dataValid),
      .dataOut      (dataOut),
      .dataWriteSuc (dataWriteSuc),
      .busy         (busy),
      .memIn        (memIn),
      .memOut       (memOut),
      .memAddr      (memAddr),
      .memWr        (memWr),
      .ioBufferFull (ioBufferFull)
   );

   always #5 clockIn = ~clockIn;

   // Synchronous RAM: address sampled at one edge, byte presented after it.
   always @(posedge clockIn) begin
      memIn <= ram[memAddr[11:0]];
      if (memWr)      ram[memAddr[11:0]] <= memOut;
      else if (preEn) ram[preAddr]       <= preData;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic poke(input logic [11:0] a, input logic [7:0] d);
      preAddr = a;
      preData = d;
      preEn   = 1'b1;
      @(posedge clockIn); #1;
      preEn   = 1'b0;
   endtask

   // Present a request for exactly one edge (edge k); returns at k+1ns.
   task automatic issue(input logic [1:0] at, input logic rw, input logic [31:0] addr,
                        input logic [31:0] data);
      accessType  = at;
      readWriteIn = rw;
      dataAddr    = addr;
      dataIn      = data;
      @(posedge clockIn); #1;
      accessType  = ACC_NONE;
   endtask

   // Sample edges j=0..cycles-1 (j=0 is the current edge); optionally present
   // an extra request so that it is sampled at edge injAt.
   task automatic watch(input int cycles, input int injAt, input logic [1:0] injType,
                        input logic injRw, input logic [31:0] injAddr, input logic [31:0] injData);
      validAt = -1; sucAt = -1; validCount = 0; sucCount = 0; wrCount = 0; bothCount = 0;
      for (int j = 0; j < cycles; j++) begin
         if (j > 0) begin
            if (j == injAt) begin
               accessType  = injType;
               readWriteIn = injRw;
               dataAddr    = injAddr;
               dataIn      = injData;
            end
            @(posedge clockIn); #1;
            accessType = ACC_NONE;
         end
         addrSeq[j] = memAddr;
         outSeq[j]  = memOut;
         wrSeq[j]   = memWr;
         busySeq[j] = busy;
         if (memWr) wrCount++;
         if (dataValid && dataWriteSuc) bothCount++;
         if (dataValid) begin
            validCount++;
            if (validAt < 0) validAt = j;
         end
         if (dataWriteSuc) begin
            sucCount++;
            if (sucAt < 0) sucAt = j;
         end
      end
   endtask

   initial begin
      resetIn      = 1'b0;
      accessType   = ACC_NONE;
      readWriteIn  = 1'b0;
      dataAddr     = '0;
      dataIn       = '0;
      ioBufferFull = 1'b0;
      #12;
      check("rst_outs", {26'd0, dataValid, dataWriteSuc, busy, memWr, |memOut, |memAddr}, 32'd0);
      check("rst_dataOut", dataOut, 32'd0);
      @(negedge clockIn);
      resetIn = 1'b1;
      @(posedge clockIn); #1;

      poke(12'h100, 8'h11); poke(12'h101, 8'h22); poke(12'h102, 8'h33); poke(12'h103, 8'h44);
      poke(12'hFFE, 8'h80); poke(12'hFFF, 8'hFF); poke(12'h007, 8'hA5);
      poke(12'h202, 8'h5A); poke(12'h204, 8'h6B); poke(12'h302, 8'h00);

      // Word read at 0x100
      issue(ACC_WORD, 1'b1, 32'h100, 32'h0);
      watch(7, -1, ACC_NONE, 1'b0, 0, 0);
      check("wr_rd_busy0", 32'(busySeq[0]), 32'd1);
      check("wr_rd_addr0", addrSeq[0], 32'h100);
      check("wr_rd_addr1", addrSeq[1], 32'h101);
      check("wr_rd_addr2", addrSeq[2], 32'h102);
      check("wr_rd_addr3", addrSeq[3], 32'h103);
      check("word_rd_validAt", 32'(validAt), 32'd5);
      check("word_rd_validCnt", 32'(validCount), 32'd1);
      check("word_rd_data", dataOut, 32'h44332211);
      check("word_rd_busyEnd", 32'(busySeq[5]), 32'd0);

      // Half read at 0x0FFE
      issue(ACC_HALF, 1'b1, 32'h0FFE, 32'h0);
      watch(5, -1, ACC_NONE, 1'b0, 0, 0);
      check("half_rd_addr1", addrSeq[1], 32'h0FFF);
      check("half_rd_validAt", 32'(validAt), 32'd3);
      check("half_rd_data", dataOut, 32'h0000FF80);

      // Byte read at 0x7
      issue(ACC_BYTE, 1'b1, 32'h7, 32'h0);
      watch(4, -1, ACC_NONE, 1'b0, 0, 0);
      check("byte_rd_validAt", 32'(validAt), 32'd2);
      check("byte_rd_validCnt", 32'(validCount), 32'd1);
      check("byte_rd_data", dataOut, 32'h000000A5);

      // Byte write 0xDEADBEAB to 0x203
      issue(ACC_BYTE, 1'b0, 32'h203, 32'hDEADBEAB);
      watch(4, -1, ACC_NONE, 1'b0, 0, 0);
      check("byte_wr_memWr0", 32'(wrSeq[0]), 32'd1);
      check("byte_wr_addr", addrSeq[0], 32'h203);
      check("byte_wr_out", 32'(outSeq[0]), 32'hAB);
      check("byte_wr_wrCnt", 32'(wrCount), 32'd1);
      check("byte_wr_sucAt", 32'(sucAt), 32'd1);
      check("byte_wr_sucCnt", 32'(sucCount), 32'd1);
      check("byte_wr_ram", 32'(ram[12'h203]), 32'hAB);
      check("byte_wr_below", 32'(ram[12'h202]), 32'h5A);
      check("byte_wr_above", 32'(ram[12'h204]), 32'h6B);
      check("dataOut_hold", dataOut, 32'h000000A5);

      // Half write 0x1234 to IO address 0x30004, buffer full for 3 edges
      ioBufferFull = 1'b1;
      issue(ACC_HALF, 1'b0, 32'h30004, 32'h1234);
      check("io_stall_k0", 32'(memWr), 32'd0);
      @(posedge clockIn); #1;
      check("io_stall_k1", 32'(memWr), 32'd0);
      @(posedge clockIn); #1;
      check("io_stall_k2", 32'(memWr), 32'd0);
      check("io_stall_busy", 32'(busy), 32'd1);
      ioBufferFull = 1'b0;
      @(posedge clockIn); #1;
      watch(4, -1, ACC_NONE, 1'b0, 0, 0);
      check("io_wr_b0_addr", addrSeq[0], 32'h30004);
      check("io_wr_b0_out", 32'(outSeq[0]), 32'h34);
      check("io_wr_b1_addr", addrSeq[1], 32'h30005);
      check("io_wr_b1_out", 32'(outSeq[1]), 32'h12);
      check("io_wr_wrCnt", 32'(wrCount), 32'd2);
      check("io_wr_sucAt_k5", 32'(sucAt), 32'd2);

      // Word read with a second request sampled 2 edges in
      issue(ACC_WORD, 1'b1, 32'h100, 32'h0);
      watch(8, 2, ACC_BYTE, 1'b0, 32'h7, 32'hFF);
      check("ovl_validCnt", 32'(validCount), 32'd1);
      check("ovl_validAt", 32'(validAt), 32'd5);
      check("ovl_noWrite", 32'(wrCount), 32'd0);
      check("ovl_busy", 32'(busySeq[0] & busySeq[1] & busySeq[2] & busySeq[3] & busySeq[4]), 32'd1);
      check("ovl_data", dataOut, 32'h44332211);
      check("ovl_ram7", 32'(ram[12'h007]), 32'hA5);
      check("ovl_both", 32'(bothCount), 32'd0);

      // Reset in the middle of a word write, after byte 1 is on the bus
      issue(ACC_WORD, 1'b0, 32'h300, 32'hCAFEF00D);
      @(posedge clockIn); #1;
      resetIn = 1'b0;
      #1;
      check("mid_rst_outs", {26'd0, dataValid, dataWriteSuc, busy, memWr, |memOut, |memAddr}, 32'd0);
      check("mid_rst_dataOut", dataOut, 32'd0);
      @(posedge clockIn); #1;
      @(negedge clockIn);
      resetIn = 1'b1;
      @(posedge clockIn); #1;
      watch(4, -1, ACC_NONE, 1'b0, 0, 0);
      check("mid_rst_noSuc", 32'(sucCount), 32'd0);
      check("mid_rst_ram0", 32'(ram[12'h300]), 32'h0D);
      check("mid_rst_ram2", 32'(ram[12'h302]), 32'h00);
      issue(ACC_BYTE, 1'b1, 32'h7, 32'h0);
      watch(4, -1, ACC_NONE, 1'b0, 0, 0);
      check("post_rst_validAt", 32'(validAt), 32'd2);
      check("post_rst_data", dataOut, 32'h000000A5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
